// File: rtl/locked_reg_pkg.sv
// ---------------------------------------------------------------------------
// locked_reg_pkg
// Shared definitions for the locked register reader: FSM state encoding and
// the default sizing/threshold values used by locked_reg_reader and
// locked_viol_counter.
// ---------------------------------------------------------------------------
package locked_reg_pkg;

  localparam int NREG_DEF        = 4;
  localparam int DW_DEF          = 16;
  localparam int VIOL_THRESH_DEF = 3;
  localparam int VIOL_CNT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/locked_viol_counter.sv
// ---------------------------------------------------------------------------
// locked_viol_counter
// Saturating count of denied accesses plus a sticky alert that rises the
// cycle after the count reaches THRESH and stays high until reset.
//
// Ports:
//   Clk    in   clock, rising edge
//   resetn in   synchronous active-low reset
//   inc    in   count one denied access this cycle
//   cnt    out  saturating denied-access count
//   alert  out  sticky security alert
// ---------------------------------------------------------------------------
module locked_viol_counter
  import locked_reg_pkg::*;
#(
  parameter int W      = VIOL_CNT_W,
  parameter int THRESH = VIOL_THRESH_DEF
) (
  input  logic         Clk,
  input  logic         resetn,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         alert
);

  localparam logic [W-1:0] THRESH_W = W'(THRESH);

  logic [W-1:0] cnt_q, cnt_d;
  logic         alert_q, alert_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Looks at the registered count, so alert lags the count by one cycle.
    alert_d = alert_q | (cnt_q >= THRESH_W);
  end

  always_ff @(posedge Clk) begin
    if (!resetn) begin
      cnt_q   <= '0;
      alert_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      alert_q <= alert_d;
    end
  end

  assign cnt   = cnt_q;
  assign alert = alert_q;

endmodule

// File: rtl/locked_reg_reader.sv
// ---------------------------------------------------------------------------
// locked_reg_reader
// Privilege-checked read port over a bank of lockable registers.
// Three-state FSM:
//   state    | meaning
//   ST_IDLE  | ready; rd_req captures address and privilege flags
//   ST_CHECK | evaluate lock/privilege/range, register response, count denial
//   ST_RESP  | rd_valid high, response held until rd_ack
//
// Ports:
//   Clk, resetn        clock / synchronous active-low reset
//   rd_req, rd_addr    request and register index (sampled in IDLE only)
//   trusted, untrusted requester privilege flags
//   reg_data           packed register contents, reg i at [i*DW +: DW]
//   lock_status        per-register lock bit, 1 = locked
//   rd_ack             consumer accepts the response (RESP only)
//   rd_ready           request can be accepted
//   rd_valid           response valid
//   rd_data, rd_err    read data / access denied
//   viol_cnt, alert    saturating denial count / sticky alert
// ---------------------------------------------------------------------------
module locked_reg_reader
  import locked_reg_pkg::*;
#(
  parameter  int NREG        = NREG_DEF,
  parameter  int DW          = DW_DEF,
  parameter  int VIOL_THRESH = VIOL_THRESH_DEF,
  localparam int AW          = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic               Clk,
  input  logic               resetn,
  input  logic               rd_req,
  input  logic [AW-1:0]      rd_addr,
  input  logic               trusted,
  input  logic               untrusted,
  input  logic [NREG*DW-1:0] reg_data,
  input  logic [NREG-1:0]    lock_status,
  input  logic               rd_ack,
  output logic               rd_ready,
  output logic               rd_valid,
  output logic [DW-1:0]      rd_data,
  output logic               rd_err,
  output logic [7:0]         viol_cnt,
  output logic               alert
);

  localparam logic [31:0] NREG_U = 32'(NREG);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          trusted_q, trusted_d;
  logic          untrusted_q, untrusted_d;
  logic [DW-1:0] data_q, data_d;
  logic          err_q, err_d;

  logic [DW-1:0] sel_data;
  logic          sel_locked;
  logic          in_range;
  logic          priv;
  logic          deny;
  logic          viol_inc;

  // Explicit compare-and-select keeps the mux in range for any NREG.
  always_comb begin
    sel_data   = '0;
    sel_locked = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (addr_q == AW'(i)) begin
        sel_data   = reg_data[i*DW +: DW];
        sel_locked = lock_status[i];
      end
    end
  end

  assign in_range = ({{(32-AW){1'b0}}, addr_q} < NREG_U);
  // Only the clean trusted-without-untrusted encoding grants privilege.
  assign priv     = trusted_q & ~untrusted_q;
  assign deny     = ~in_range | (sel_locked & ~priv);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    trusted_d   = trusted_q;
    untrusted_d = untrusted_q;
    data_d      = data_q;
    err_d       = err_q;
    viol_inc    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          addr_d      = rd_addr;
          trusted_d   = trusted;
          untrusted_d = untrusted;
          state_d     = ST_CHECK;
        end
      end
      ST_CHECK: begin
        data_d   = deny ? '0 : sel_data;
        err_d    = deny;
        viol_inc = deny;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rd_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      trusted_q   <= 1'b0;
      untrusted_q <= 1'b0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      trusted_q   <= trusted_d;
      untrusted_q <= untrusted_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  locked_viol_counter #(
    .W      (8),
    .THRESH (VIOL_THRESH)
  ) u_viol (
    .Clk    (Clk),
    .resetn (resetn),
    .inc    (viol_inc),
    .cnt    (viol_cnt),
    .alert  (alert)
  );

  assign rd_ready = (state_q == ST_IDLE);
  assign rd_valid = (state_q == ST_RESP);
  assign rd_data  = data_q;
  assign rd_err   = err_q;

endmodule

// File: doc/locked_reg_reader.md
LOCKED_REG_READER -- requirements
Module: locked_reg_reader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NREG, 4: number of lockable 16-bit registers.
- DW, 16: register data width.
- VIOL_THRESH, 3: violation count at which alert asserts.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- Clk, in, 1: sole clock; all logic on the rising edge.
- resetn, in, 1: synchronous, active-low reset.
- rd_req, in, 1: read request, sampled only when rd_ready=1.
- rd_addr, in, clog2(NREG): register index.
- trusted, in, 1: requester privilege flag.
- untrusted, in, 1: requester non-privilege flag.
- reg_data, in, NREG*DW: register contents; register i occupies bits [i*DW +: DW].
- lock_status, in, NREG: per-register lock bit; 1 means locked.
- rd_ack, in, 1: consumer accepts the response.
- rd_ready, out, 1: high when a request can be accepted (state IDLE).
- rd_valid, out, 1: response valid.
- rd_data, out, DW: read data.
- rd_err, out, 1: access denied.
- viol_cnt, out, 8: saturating denied-access count.
- alert, out, 1: sticky security alert.

Function
REQ-003 The FSM SHALL have three states: IDLE, CHECK, RESP.
REQ-004 In IDLE, rd_req=1 SHALL capture rd_addr, trusted and untrusted, and move the FSM to CHECK.
REQ-005 In CHECK, the block SHALL evaluate access against reg_data and lock_status sampled in that cycle, register rd_data and rd_err, and move the FSM to RESP.
REQ-006 In RESP, rd_valid SHALL be 1 and rd_data/rd_err SHALL hold stable; rd_ack=1 SHALL return the FSM to IDLE.
REQ-007 Latency SHALL be 2 cycles from request acceptance to rd_valid; back-to-back throughput SHALL be at most one read per 3 cycles.
REQ-008 The effective privilege SHALL be trusted: captured trusted=1 and untrusted=0. Any other combination SHALL be treated as untrusted, including both set and neither set.
REQ-009 An unlocked register SHALL be readable by any requester: rd_data=register value, rd_err=0.
REQ-010 A locked register read by a trusted requester SHALL return rd_data=register value, rd_err=0.
REQ-011 A locked register read by an untrusted requester SHALL return rd_data=0, rd_err=1.
REQ-012 An address >= NREG SHALL return rd_data=0, rd_err=1, regardless of privilege.
REQ-013 Each rd_err=1 result SHALL increment viol_cnt by 1 in the CHECK cycle; viol_cnt SHALL saturate at 255.
REQ-014 alert SHALL assert in the cycle after viol_cnt reaches VIOL_THRESH and SHALL remain 1 until reset.
REQ-015 rd_req while not in IDLE SHALL be ignored and SHALL NOT be queued.
REQ-016 rd_ack outside RESP SHALL be ignored.
REQ-017 A lock_status change during RESP SHALL NOT alter the held response.

Reset
REQ-018 With resetn=0 at a Clk edge, the FSM SHALL go to IDLE, with rd_valid=0, rd_data=0, rd_err=0, viol_cnt=0 and alert=0. rd_ready SHALL be 1 from the following cycle.
REQ-019 Reset during CHECK or RESP SHALL abort the transaction with no response and no count update.

Structure
REQ-020 Package locked_reg_pkg SHALL hold the state enum typedef and the NREG, DW and VIOL_THRESH defaults.
REQ-021 The saturating counter plus sticky alert SHALL be a sub-module, locked_viol_counter (inputs inc and resetn; outputs cnt and alert).

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Unlocked read: reg1=16'hA5A5, lock=0000, untrusted read of addr 1 -> rd_valid at cycle +2, rd_data=16'hA5A5, rd_err=0.
- Locked trusted read: lock[2]=1, reg2=16'h1234, trusted=1/untrusted=0 -> rd_data=16'h1234, rd_err=0, viol_cnt unchanged.
- Denied reads: lock[0]=1; three reads of addr 0 with trusted=1 and untrusted=1 -> each rd_data=0, rd_err=1; viol_cnt=3; alert=1 after the third read and persisting.
- Backpressure: rd_ack held 0 for 5 cycles, new rd_req pulsed, lock_status toggled -> response stable, rd_ready=0, extra request dropped.
- Reset mid-op: resetn=0 in the CHECK cycle -> no rd_valid; viol_cnt=0; rd_ready=1 on the next cycle.
- Saturation: 260 denied reads -> viol_cnt=255.
